// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite draw scheduler: FSM state encoding
// and the fixed shape/colour driven to the plot engine during an erase pass.
package sprite_sched_pkg;

    localparam int SHAPE_W = 25;
    localparam int COL_W   = 3;

    localparam logic [SHAPE_W-1:0] ERASE_SHAPE = 25'h1FFFFFF;
    localparam logic [COL_W-1:0]   ERASE_COL   = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LATCH      = 3'd1,
        S_ERASE_GO   = 3'd2,
        S_ERASE_WAIT = 3'd3,
        S_DRAW_GO    = 3'd4,
        S_DRAW_WAIT  = 3'd5,
        S_ACK        = 3'd6
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// the pointer, wrapping, and returns it both one-hot and as an index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares one 5x5 tile plot engine among NUM_REQ sprites: erase old tile, draw new, ack.
// Optional SPRITE_SKIP_UNCHANGED_EN: acks an unchanged redraw without any engine passes.
module sprite_draw_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*SHAPE_W-1:0] req_shape,
    input  logic [NUM_REQ*COL_W-1:0]   req_col,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic                       eng_go,
    output logic                       eng_erase,
    output logic [X_W-1:0]             eng_x,
    output logic [Y_W-1:0]             eng_y,
    output logic [SHAPE_W-1:0]         eng_shape,
    output logic [COL_W-1:0]           eng_col,
    input  logic                       eng_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_next;
    logic [IDX_W-1:0]     rr_ptr, gnt_idx, arb_idx;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [NUM_REQ-1:0]   old_valid;
    logic [X_W-1:0]       old_x [NUM_REQ];
    logic [Y_W-1:0]       old_y [NUM_REQ];
    logic [X_W-1:0]       lat_x;
    logic [Y_W-1:0]       lat_y;
    logic [SHAPE_W-1:0]   lat_shape;
    logic [COL_W-1:0]     lat_col;

`ifdef SPRITE_SKIP_UNCHANGED_EN
    logic [SHAPE_W-1:0]   old_shape [NUM_REQ];
    logic [COL_W-1:0]     old_col   [NUM_REQ];
    logic                 skip_hit;

    // Compared against the values being latched this cycle, not the stale latch regs.
    assign skip_hit = old_valid[gnt_idx]
                   && (req_x[gnt_idx*X_W +: X_W] == old_x[gnt_idx])
                   && (req_y[gnt_idx*Y_W +: Y_W] == old_y[gnt_idx])
                   && (req_shape[gnt_idx*SHAPE_W +: SHAPE_W] == old_shape[gnt_idx])
                   && (req_col[gnt_idx*COL_W +: COL_W] == old_col[gnt_idx]);
`endif

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:       if (|arb_grant) state_next = S_LATCH;
            S_LATCH: begin
                state_next = old_valid[gnt_idx] ? S_ERASE_GO : S_DRAW_GO;
`ifdef SPRITE_SKIP_UNCHANGED_EN
                if (skip_hit) state_next = S_ACK;
`endif
            end
            S_ERASE_GO:   state_next = S_ERASE_WAIT;
            S_ERASE_WAIT: if (eng_done) state_next = S_DRAW_GO;
            S_DRAW_GO:    state_next = S_DRAW_WAIT;
            S_DRAW_WAIT:  if (eng_done) state_next = S_ACK;
            S_ACK:        state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack       = '0;
        busy      = (state != S_IDLE);
        eng_go    = 1'b0;
        eng_erase = 1'b0;
        eng_x     = '0;
        eng_y     = '0;
        eng_shape = '0;
        eng_col   = '0;
        case (state)
            S_ERASE_GO, S_ERASE_WAIT: begin
                eng_go    = (state == S_ERASE_GO);
                eng_erase = 1'b1;
                eng_x     = old_x[gnt_idx];
                eng_y     = old_y[gnt_idx];
                eng_shape = ERASE_SHAPE;
                eng_col   = ERASE_COL;
            end
            S_DRAW_GO, S_DRAW_WAIT: begin
                eng_go    = (state == S_DRAW_GO);
                eng_x     = lat_x;
                eng_y     = lat_y;
                eng_shape = lat_shape;
                eng_col   = lat_col;
            end
            S_ACK:   ack[gnt_idx] = 1'b1;
            default: ;
        endcase
    end

    // History only moves in ACK, so an abandoned pass leaves it untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            old_valid <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_shape <= '0;
            lat_col   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                old_x[i] <= '0;
                old_y[i] <= '0;
`ifdef SPRITE_SKIP_UNCHANGED_EN
                old_shape[i] <= '0;
                old_col[i]   <= '0;
`endif
            end
        end else begin
            if (state == S_IDLE && (|arb_grant)) gnt_idx <= arb_idx;
            if (state == S_LATCH) begin
                lat_x     <= req_x[gnt_idx*X_W +: X_W];
                lat_y     <= req_y[gnt_idx*Y_W +: Y_W];
                lat_shape <= req_shape[gnt_idx*SHAPE_W +: SHAPE_W];
                lat_col   <= req_col[gnt_idx*COL_W +: COL_W];
            end
            if (state == S_ACK) begin
                old_x[gnt_idx]     <= lat_x;
                old_y[gnt_idx]     <= lat_y;
                old_valid[gnt_idx] <= 1'b1;
`ifdef SPRITE_SKIP_UNCHANGED_EN
                old_shape[gnt_idx] <= lat_shape;
                old_col[gnt_idx]   <= lat_col;
`endif
                if (gnt_idx == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
                else                                rr_ptr <= gnt_idx + 1'b1;
            end
        end
    end

endmodule
